i2c_txn_scheduler: RTL and testbench
====================================

// Module: i2c_txn_scheduler
// PURPOSE
// - Arbitrates queued AXI-lite write and read requests onto the single i2c_master engine, one transaction at a time.
// - Round-robin between the write and read requesters; issues start, waits for done/NACK/timeout, returns a response.
// - Sits between axi_slave request/response staging and i2c_master; replaces ad-hoc trigger/ack wiring between them.
// PARAMETERS
// - ADDR_W          16    I2C address field: {7b device addr, 1b rsvd, 8b register addr}
// - DATA_W          8     I2C data byte width
// - TIMEOUT_CYCLES  4096  ACLK cycles from I2C_START to I2C_DONE before abort; 0 = timeout disabled
// PORTS
// - ACLK            in   1       clock, all logic on rising edge
// - ARESET          in   1       reset: synchronous, active-high
// - WR_REQ_VALID    in   1       write request pending
// - WR_REQ_READY    out  1       write request accepted this cycle
// - WR_REQ_ADDR     in   ADDR_W  write target address
// - WR_REQ_DATA     in   DATA_W  write byte
// - RD_REQ_VALID    in   1       read request pending
// - RD_REQ_READY    out  1       read request accepted this cycle
// - RD_REQ_ADDR     in   ADDR_W  read target address
// - WR_RSP_VALID    out  1       write response valid
// - WR_RSP_READY    in   1       write response consumed
// - WR_RSP_ERR      out  2       00 OKAY, 10 NACK, 11 timeout
// - RD_RSP_VALID    out  1       read response valid
// - RD_RSP_READY    in   1       read response consumed
// - RD_RSP_DATA     out  DATA_W  read byte; 0 when RD_RSP_ERR != 00
// - RD_RSP_ERR      out  2       as WR_RSP_ERR
// - I2C_START       out  1       one-cycle pulse: launch transaction
// - I2C_ABORT       out  1       one-cycle pulse: force STOP/idle on timeout
// - I2C_RW          out  1       1 = read, 0 = write; held stable from START to DONE
// - I2C_ADDR        out  ADDR_W  held stable from START to DONE
// - I2C_WDATA       out  DATA_W  held stable from START to DONE
// - I2C_BUSY        in   1       engine busy; START is issued only when low
// - I2C_DONE        in   1       one-cycle pulse: transaction finished
// - I2C_NACK        in   1       sampled with I2C_DONE
// - I2C_RDATA       in   DATA_W  sampled with I2C_DONE
// - SCHED_BUSY      out  1       state != IDLE
// BEHAVIOUR
// - Reset: state = IDLE; all outputs 0; last_grant = RD, so a write wins the first tie; timer = 0.
// - FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// - IDLE: grant is combinational. One valid requester is granted. Both valid: grant the requester != last_grant.
//   - The granted READY is high this cycle; addr/data/rw are captured; last_grant is updated; go to ISSUE.
//   - READY is never high outside IDLE. At most one READY is high per cycle.
// - ISSUE: if !I2C_BUSY, pulse I2C_START, clear timer, go to WAIT; otherwise hold in ISSUE.
//   - Earliest START is the cycle after acceptance.
// - WAIT: timer increments each cycle.
//   - I2C_DONE: capture ERR = NACK ? 10 : 00, and RDATA for reads; go to RESP.
//   - Timer reaches TIMEOUT_CYCLES-1 without DONE: pulse I2C_ABORT, ERR = 11, go to RESP.
//   - DONE and timeout in the same cycle: DONE wins, no abort.
// - RESP: assert the RSP_VALID matching the captured rw, with ERR/DATA stable; hold until the matching RSP_READY.
//   - On the handshake, drop VALID next cycle and return to IDLE; the new grant is possible the same cycle as the VALID drop.
// - Latency: accept -> START 1 cycle min; DONE -> RSP_VALID 1 cycle.
//   - Back-to-back throughput is >= 4 cycles plus engine time.
// - Spurious I2C_DONE outside WAIT is ignored. Request inputs are ignored outside IDLE.
// - ARESET mid-transaction: return to IDLE in 1 cycle; the in-flight transaction is dropped with no response;
//   - no START/ABORT pulse in the reset cycle; i2c_master is reset by the same ARESET.
// TESTING
// - Single write 0x5010/0xA5: READY 1 cycle -> START next cycle, RW=0, ADDR=0x5010, WDATA=0xA5; DONE, NACK=0 -> WR_RSP_VALID, ERR=00.
// - Read 0x5020, engine returns RDATA=0x3C -> RD_RSP_VALID next cycle, DATA=0x3C, ERR=00; RD_RSP_READY low 5 cycles -> VALID/DATA held.
// - Both VALID held for 4 transactions -> grant order WR,RD,WR,RD; never two READYs in one cycle.
// - NACK on read -> RD_RSP_ERR=10, RD_RSP_DATA=0; TIMEOUT_CYCLES=16, no DONE -> ABORT pulse 16 cycles after START, ERR=11.
// - I2C_BUSY high 10 cycles after accept -> START delayed to the first BUSY-low cycle.
//   - ARESET in WAIT -> SCHED_BUSY=0 next cycle, no RSP_VALID, next request is served normally.

Source files
------------

// File: rtl/i2c_txn_scheduler.sv
// i2c_txn_scheduler: round-robin write/read arbiter feeding one i2c_master.
// One transaction in flight; start, wait for done/nack/timeout, respond.
`timescale 1ns/1ps
module i2c_txn_scheduler #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              WR_REQ_VALID,
  output logic              WR_REQ_READY,
  input  logic [ADDR_W-1:0] WR_REQ_ADDR,
  input  logic [DATA_W-1:0] WR_REQ_DATA,
  input  logic              RD_REQ_VALID,
  output logic              RD_REQ_READY,
  input  logic [ADDR_W-1:0] RD_REQ_ADDR,
  output logic              WR_RSP_VALID,
  input  logic              WR_RSP_READY,
  output logic [1:0]        WR_RSP_ERR,
  output logic              RD_RSP_VALID,
  input  logic              RD_RSP_READY,
  output logic [DATA_W-1:0] RD_RSP_DATA,
  output logic [1:0]        RD_RSP_ERR,
  output logic              I2C_START,
  output logic              I2C_ABORT,
  output logic              I2C_RW,
  output logic [ADDR_W-1:0] I2C_ADDR,
  output logic [DATA_W-1:0] I2C_WDATA,
  input  logic              I2C_BUSY,
  input  logic              I2C_DONE,
  input  logic              I2C_NACK,
  input  logic [DATA_W-1:0] I2C_RDATA,
  output logic              SCHED_BUSY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TLAST_I =
    (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TW-1:0] T_LAST = TW'(TLAST_I);
  localparam logic TO_EN = (TIMEOUT_CYCLES != 0);

  state_t            state_q, state_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              last_rd_q, last_rd_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic wr_gnt;
  logic rd_gnt;
  logic timeout_hit;
  logic rsp_hs;

  // Arbitration, next-state and handshake outputs.
  always_comb begin
    state_d      = state_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    last_rd_d    = last_rd_q;
    timer_d      = timer_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    WR_REQ_READY = 1'b0;
    RD_REQ_READY = 1'b0;
    WR_RSP_VALID = 1'b0;
    RD_RSP_VALID = 1'b0;
    I2C_START    = 1'b0;
    I2C_ABORT    = 1'b0;
    wr_gnt       = WR_REQ_VALID &&
                   (!RD_REQ_VALID || last_rd_q);
    rd_gnt       = RD_REQ_VALID && !wr_gnt;
    timeout_hit  = TO_EN && (timer_q == T_LAST);
    rsp_hs       = rw_q ? RD_RSP_READY : WR_RSP_READY;

    unique case (state_q)
      S_IDLE: begin
        if (wr_gnt || rd_gnt) begin
          WR_REQ_READY = wr_gnt;
          RD_REQ_READY = rd_gnt;
          rw_d         = rd_gnt;
          addr_d       = rd_gnt ? RD_REQ_ADDR : WR_REQ_ADDR;
          wdata_d      = rd_gnt ? '0 : WR_REQ_DATA;
          last_rd_d    = rd_gnt;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!I2C_BUSY) begin
          I2C_START = 1'b1;
          timer_d   = '0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (I2C_DONE) begin
          err_d   = I2C_NACK ? 2'b10 : 2'b00;
          rdata_d = (rw_q && !I2C_NACK) ? I2C_RDATA : '0;
          state_d = S_RESP;
        end else if (timeout_hit) begin
          I2C_ABORT = 1'b1;
          err_d     = 2'b11;
          rdata_d   = '0;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        WR_RSP_VALID = !rw_q;
        RD_RSP_VALID = rw_q;
        if (rsp_hs) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (ARESET) begin
      WR_REQ_READY = 1'b0;
      RD_REQ_READY = 1'b0;
      I2C_START    = 1'b0;
      I2C_ABORT    = 1'b0;
    end
  end

  // State and captured transaction registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= S_IDLE;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      last_rd_q <= 1'b1;
      timer_q   <= '0;
      err_q     <= 2'b00;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      last_rd_q <= last_rd_d;
      timer_q   <= timer_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign WR_RSP_ERR  = WR_RSP_VALID ? err_q : 2'b00;
  assign RD_RSP_ERR  = RD_RSP_VALID ? err_q : 2'b00;
  assign RD_RSP_DATA = RD_RSP_VALID ? rdata_q : '0;
  assign I2C_RW      = rw_q;
  assign I2C_ADDR    = addr_q;
  assign I2C_WDATA   = wdata_q;
  assign SCHED_BUSY  = (state_q != S_IDLE);

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// tb_i2c_txn_scheduler: scoreboard bench with a behavioural i2c engine.
// Directed scenarios followed by a randomized two-requester phase.
`timescale 1ns/1ps
module tb_i2c_txn_scheduler;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          WR_REQ_VALID;
  logic          WR_REQ_READY;
  logic [AW-1:0] WR_REQ_ADDR;
  logic [DW-1:0] WR_REQ_DATA;
  logic          RD_REQ_VALID;
  logic          RD_REQ_READY;
  logic [AW-1:0] RD_REQ_ADDR;
  logic          WR_RSP_VALID;
  logic          WR_RSP_READY;
  logic [1:0]    WR_RSP_ERR;
  logic          RD_RSP_VALID;
  logic          RD_RSP_READY;
  logic [DW-1:0] RD_RSP_DATA;
  logic [1:0]    RD_RSP_ERR;
  logic          I2C_START;
  logic          I2C_ABORT;
  logic          I2C_RW;
  logic [AW-1:0] I2C_ADDR;
  logic [DW-1:0] I2C_WDATA;
  logic          I2C_BUSY;
  logic          I2C_DONE;
  logic          I2C_NACK;
  logic [DW-1:0] I2C_RDATA;
  logic          SCHED_BUSY;

  logic eng_done = 1'b0;
  logic spur_done = 1'b0;
  logic busy_main = 1'b0;
  logic busy_rand = 1'b0;
  assign I2C_DONE = eng_done | spur_done;
  assign I2C_BUSY = busy_main | busy_rand;

  i2c_txn_scheduler #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .WR_REQ_VALID(WR_REQ_VALID), .WR_REQ_READY(WR_REQ_READY),
    .WR_REQ_ADDR(WR_REQ_ADDR), .WR_REQ_DATA(WR_REQ_DATA),
    .RD_REQ_VALID(RD_REQ_VALID), .RD_REQ_READY(RD_REQ_READY),
    .RD_REQ_ADDR(RD_REQ_ADDR),
    .WR_RSP_VALID(WR_RSP_VALID), .WR_RSP_READY(WR_RSP_READY),
    .WR_RSP_ERR(WR_RSP_ERR),
    .RD_RSP_VALID(RD_RSP_VALID), .RD_RSP_READY(RD_RSP_READY),
    .RD_RSP_DATA(RD_RSP_DATA), .RD_RSP_ERR(RD_RSP_ERR),
    .I2C_START(I2C_START), .I2C_ABORT(I2C_ABORT),
    .I2C_RW(I2C_RW), .I2C_ADDR(I2C_ADDR), .I2C_WDATA(I2C_WDATA),
    .I2C_BUSY(I2C_BUSY), .I2C_DONE(I2C_DONE),
    .I2C_NACK(I2C_NACK), .I2C_RDATA(I2C_RDATA),
    .SCHED_BUSY(SCHED_BUSY)
  );

  always #5 ACLK = ~ACLK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  typedef struct {
    logic          rw;
    logic [1:0]    err;
    logic [DW-1:0] data;
    int            due;
  } rsp_t;

  txn_t txn_q[$];
  rsp_t exp_q[$];
  logic grant_log[$];
  int   acc_cyc = 0;
  int   abort_due = -1;
  logic model_last_rd = 1'b1;
  logic prev_v = 1'b0;

  // engine outcome controls
  logic          force_en = 1'b1;
  int            f_delay = 3;
  logic          f_nack = 1'b0;
  logic [DW-1:0] f_rdata = '0;
  int            rsp_mode = 1;
  logic          busy_mode = 1'b0;

  // monitor: grants, starts, aborts and responses
  txn_t m_t;
  rsp_t m_e;
  logic m_exp_rd;
  logic m_hs;
  always @(negedge ACLK) begin
    if (ARESET) begin
      txn_q.delete();
      exp_q.delete();
      abort_due = -1;
      model_last_rd = 1'b1;
      prev_v = 1'b0;
    end else begin
      if (I2C_START) begin
        chk("start_busy", I2C_BUSY, 0);
        if (txn_q.size() == 0) begin
          chk("start_unexpected", 1, 0);
        end else begin
          m_t = txn_q.pop_front();
          chk("start_rw", I2C_RW, m_t.rw);
          chk("start_addr", I2C_ADDR, m_t.addr);
          if (!m_t.rw) chk("start_wdata", I2C_WDATA, m_t.data);
        end
      end else if (txn_q.size() > 0 && !I2C_BUSY &&
                   cyc > acc_cyc) begin
        chk("start_late", 0, 1);
      end

      if (I2C_ABORT || cyc == abort_due)
        chk("abort", I2C_ABORT, cyc == abort_due);

      if (WR_REQ_READY || RD_REQ_READY) begin
        chk("one_ready", WR_REQ_READY & RD_REQ_READY, 0);
        chk("ready_idle", SCHED_BUSY, 0);
        m_exp_rd = RD_REQ_VALID &&
                   (!WR_REQ_VALID || !model_last_rd);
        chk("grant_rd", RD_REQ_READY, m_exp_rd);
        chk("grant_valid",
            RD_REQ_READY ? RD_REQ_VALID : WR_REQ_VALID, 1);
        m_t.rw   = RD_REQ_READY;
        m_t.addr = RD_REQ_READY ? RD_REQ_ADDR : WR_REQ_ADDR;
        m_t.data = WR_REQ_DATA;
        txn_q.push_back(m_t);
        grant_log.push_back(RD_REQ_READY);
        model_last_rd = RD_REQ_READY;
        acc_cyc = cyc;
      end else if (!SCHED_BUSY &&
                   (WR_REQ_VALID || RD_REQ_VALID)) begin
        chk("grant_missing", 0, 1);
      end

      m_hs = 1'b0;
      if (WR_RSP_VALID || RD_RSP_VALID) begin
        chk("one_rsp", WR_RSP_VALID & RD_RSP_VALID, 0);
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          m_e = exp_q[0];
          chk("rsp_chan", RD_RSP_VALID, m_e.rw);
          if (!prev_v) chk("rsp_latency", cyc, m_e.due);
          chk("rsp_err",
              RD_RSP_VALID ? RD_RSP_ERR : WR_RSP_ERR, m_e.err);
          if (RD_RSP_VALID) chk("rsp_data", RD_RSP_DATA, m_e.data);
          m_hs = RD_RSP_VALID ? RD_RSP_READY : WR_RSP_READY;
          if (m_hs) void'(exp_q.pop_front());
        end
      end
      prev_v = (WR_RSP_VALID || RD_RSP_VALID) && !m_hs;
    end
  end

  // behavioural engine: predicts the response when it launches
  int            e_d;
  int            e_s;
  logic          e_nk;
  logic [DW-1:0] e_rdv;
  logic [AW-1:0] e_a;
  rsp_t          e_e;
  always @(negedge ACLK) begin
    if (I2C_START && !ARESET) begin
      e_s = cyc;
      e_a = I2C_ADDR;
      if (force_en) begin
        e_d = f_delay; e_nk = f_nack; e_rdv = f_rdata;
      end else begin
        e_d = ($urandom_range(0, 4) == 0) ? 0
            : int'($urandom_range(1, TO));
        e_nk = ($urandom_range(0, 3) == 0);
        e_rdv = DW'($urandom);
      end
      e_e.rw = I2C_RW;
      if (e_d == 0) begin
        e_e.err = 2'b11;
        e_e.data = '0;
        e_e.due = e_s + TO + 1;
        abort_due = e_s + TO;
      end else begin
        e_e.err = e_nk ? 2'b10 : 2'b00;
        e_e.data = (I2C_RW && !e_nk) ? e_rdv : '0;
        e_e.due = e_s + e_d + 1;
      end
      exp_q.push_back(e_e);
      if (e_d != 0) begin
        repeat (e_d) @(posedge ACLK);
        #1;
        eng_done = 1'b1; I2C_NACK = e_nk; I2C_RDATA = e_rdv;
        @(negedge ACLK);
        chk("addr_hold", I2C_ADDR, e_a);
        @(posedge ACLK);
        #1;
        eng_done = 1'b0; I2C_NACK = 1'b0; I2C_RDATA = '0;
      end
    end
  end

  // response-ready and random busy drivers
  always @(posedge ACLK) begin
    #1;
    case (rsp_mode)
      0: begin
        WR_RSP_READY = ($urandom_range(0, 2) == 0);
        RD_RSP_READY = ($urandom_range(0, 2) == 0);
      end
      1: begin WR_RSP_READY = 1'b1; RD_RSP_READY = 1'b1; end
      default: begin WR_RSP_READY = 1'b0; RD_RSP_READY = 1'b0; end
    endcase
    busy_rand = busy_mode && ($urandom_range(0, 3) == 0);
  end

  task automatic wr_req(input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    int n;
    WR_REQ_VALID = 1'b1; WR_REQ_ADDR = a; WR_REQ_DATA = d;
    n = 0;
    do begin @(negedge ACLK); n++; end
    while (!WR_REQ_READY && n < 300);
    if (!WR_REQ_READY) chk("wr_accept_timeout", 0, 1);
    @(posedge ACLK); #1;
  endtask

  task automatic rd_req(input logic [AW-1:0] a);
    int n;
    RD_REQ_VALID = 1'b1; RD_REQ_ADDR = a;
    n = 0;
    do begin @(negedge ACLK); n++; end
    while (!RD_REQ_READY && n < 300);
    if (!RD_REQ_READY) chk("rd_accept_timeout", 0, 1);
    @(posedge ACLK); #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge ACLK); n++; end
    while ((SCHED_BUSY || exp_q.size() != 0) && n < 500);
    if (SCHED_BUSY || exp_q.size() != 0) chk("idle_timeout", 0, 1);
    @(posedge ACLK); #1;
  endtask

  task automatic gap(input int g);
    repeat (g) begin @(posedge ACLK); #1; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    ARESET = 1'b1;
    WR_REQ_VALID = 1'b0; WR_REQ_ADDR = '0; WR_REQ_DATA = '0;
    RD_REQ_VALID = 1'b0; RD_REQ_ADDR = '0;
    WR_RSP_READY = 1'b0; RD_RSP_READY = 1'b0;
    I2C_NACK = 1'b0; I2C_RDATA = '0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_ctrl", {SCHED_BUSY, WR_REQ_READY, RD_REQ_READY,
                     WR_RSP_VALID, RD_RSP_VALID, I2C_START,
                     I2C_ABORT, I2C_RW}, 0);
    chk("rst_data", {I2C_ADDR, I2C_WDATA}, 0);
    chk("rst_rsp", {WR_RSP_ERR, RD_RSP_ERR, RD_RSP_DATA}, 0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;

    // single write, minimum start latency
    f_delay = 3;
    wr_req(16'h5010, 8'hA5);
    WR_REQ_VALID = 1'b0;
    wait_idle();

    // read with held response
    f_delay = 5; f_rdata = 8'h3C; rsp_mode = 2;
    rd_req(16'h5020);
    RD_REQ_VALID = 1'b0;
    n = 0;
    do begin @(negedge ACLK); n++; end
    while (!RD_RSP_VALID && n < 100);
    chk("rd_rsp_seen", RD_RSP_VALID, 1);
    repeat (5) @(negedge ACLK);
    chk("rd_hold_valid", RD_RSP_VALID, 1);
    chk("rd_hold_data", RD_RSP_DATA, 8'h3C);
    @(posedge ACLK); #1;
    rsp_mode = 1;
    wait_idle();

    // both requesters held: alternating grants
    grant_log.delete();
    rsp_mode = 0; f_delay = 2;
    fork
      begin
        wr_req(16'h1111, 8'h11);
        wr_req(16'h2222, 8'h22);
        WR_REQ_VALID = 1'b0;
      end
      begin
        rd_req(16'h3333);
        rd_req(16'h4444);
        RD_REQ_VALID = 1'b0;
      end
    join
    wait_idle();
    chk("rr_count", grant_log.size(), 4);
    if (grant_log.size() == 4)
      chk("rr_order", {grant_log[0], grant_log[1],
                       grant_log[2], grant_log[3]}, 4'b0101);
    rsp_mode = 1;

    // nack on read
    f_delay = 4; f_nack = 1'b1; f_rdata = 8'h77;
    rd_req(16'h5030);
    RD_REQ_VALID = 1'b0;
    wait_idle();
    f_nack = 1'b0;

    // timeouts, and done on the last timer cycle
    f_delay = 0;
    rd_req(16'h5040);
    RD_REQ_VALID = 1'b0;
    wait_idle();
    wr_req(16'h5050, 8'h0F);
    WR_REQ_VALID = 1'b0;
    wait_idle();
    f_delay = TO; f_rdata = 8'hE1;
    rd_req(16'h5060);
    RD_REQ_VALID = 1'b0;
    wait_idle();

    // engine busy after accept delays start
    f_delay = 2;
    busy_main = 1'b1;
    wr_req(16'h6060, 8'h5A);
    WR_REQ_VALID = 1'b0;
    gap(10);
    busy_main = 1'b0;
    wait_idle();

    // reset while waiting on the engine
    f_delay = 0;
    rd_req(16'h7070);
    RD_REQ_VALID = 1'b0;
    gap(4);
    chk("mid_wait_busy", SCHED_BUSY, 1);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("rst_mid_busy", SCHED_BUSY, 0);
    chk("rst_mid_rsp", {WR_RSP_VALID, RD_RSP_VALID}, 0);
    @(posedge ACLK); #1;
    gap(20);
    f_delay = 4;
    wr_req(16'h7171, 8'h71);
    WR_REQ_VALID = 1'b0;
    wait_idle();

    // spurious done while idle
    spur_done = 1'b1;
    gap(1);
    spur_done = 1'b0;
    gap(3);
    @(negedge ACLK);
    chk("spur_idle", SCHED_BUSY, 0);
    @(posedge ACLK); #1;

    // randomized phase
    force_en = 1'b0; rsp_mode = 0; busy_mode = 1'b1;
    fork
      begin
        repeat (20) begin
          WR_REQ_VALID = 1'b0;
          gap($urandom_range(0, 3));
          wr_req(AW'($urandom), DW'($urandom));
        end
        WR_REQ_VALID = 1'b0;
      end
      begin
        repeat (20) begin
          RD_REQ_VALID = 1'b0;
          gap($urandom_range(0, 3));
          rd_req(AW'($urandom));
        end
        RD_REQ_VALID = 1'b0;
      end
    join
    busy_mode = 1'b0;
    rsp_mode = 1;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
